word_tx_serializer: RTL and testbench

Splits a parallel word into a sequence of bytes and feeds them, one at a time, to the debug unit's UART transmitter. This is the outgoing counterpart of the byte-to-word path: register-file, memory and PC contents leave the pipeline through this block. The upstream side uses a valid/ready word handshake. The downstream side uses the transmitter's start/done pulse pair.

---
 rtl/word_tx_serializer.sv | 90 +++++++++
 tb/tb_word_tx_serializer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/word_tx_serializer.sv
// Word-to-byte serializer feeding the debug UART transmitter.
// Accepts a word on a valid/ready handshake and emits its bytes over a start/done pulse pair.
module word_tx_serializer #(
    parameter int unsigned NB_WORD   = 32,
    parameter int unsigned NB_BYTE   = 8,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NB_WORD-1:0] i_word,
    input  logic               i_word_valid,
    output logic               o_word_ready,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_start,
    input  logic               i_tx_done,
    output logic               o_busy,
    output logic               o_done
);
    localparam int unsigned       N_BYTES  = NB_WORD / NB_BYTE;
    localparam int unsigned       NB_CNT   = $clog2(N_BYTES) + 1;
    localparam logic [NB_CNT-1:0] LAST_IDX = NB_CNT'(N_BYTES - 1);

    typedef enum logic [1:0] {StIdle, StSend, StWait, StDone} state_e;

    state_e             r_state;
    state_e             w_state_next;
    logic [NB_WORD-1:0] r_shift;
    logic [NB_WORD-1:0] w_shift_next;
    logic [NB_WORD-1:0] w_shift_adv;
    logic [NB_CNT-1:0]  r_cnt;
    logic [NB_CNT-1:0]  w_cnt_next;

    // The byte on the wire always sits at the send end; advancing moves the next one there.
    generate
        if (LSB_FIRST) begin : g_lsb_first
            assign o_tx_data   = r_shift[NB_BYTE-1:0];
            assign w_shift_adv = r_shift >> NB_BYTE;
        end else begin : g_msb_first
            assign o_tx_data   = r_shift[NB_WORD-1 -: NB_BYTE];
            assign w_shift_adv = r_shift << NB_BYTE;
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_shift <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_shift <= w_shift_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_shift_next = r_shift;
        w_cnt_next   = r_cnt;
        unique case (r_state)
            StIdle: begin
                if (i_word_valid) begin
                    w_shift_next = i_word;
                    w_cnt_next   = '0;
                    w_state_next = StSend;
                end
            end
            StSend: w_state_next = StWait;
            StWait: begin
                if (i_tx_done) begin
                    if (r_cnt == LAST_IDX) begin
                        w_state_next = StDone;
                    end else begin
                        w_cnt_next   = r_cnt + NB_CNT'(1);
                        w_shift_next = w_shift_adv;
                        w_state_next = StSend;
                    end
                end
            end
            StDone: w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    assign o_word_ready = (r_state == StIdle);
    assign o_tx_start   = (r_state == StSend);
    assign o_busy       = (r_state != StIdle);
    assign o_done       = (r_state == StDone);

endmodule

// File: tb/tb_word_tx_serializer.sv
// Bench for word_tx_serializer: randomized upstream/UART stimulus on the default build checked
// against a transaction-level model, plus directed runs of MSB-first and single-byte builds.
module tb_word_tx_serializer;
    localparam int unsigned N_BYTES = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Default build
    logic        rst_n, valid, ready, tx_start, tx_done, busy, done;
    logic [31:0] word;
    logic [7:0]  tx_data;

    word_tx_serializer u_dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_word      (word),
        .i_word_valid(valid),
        .o_word_ready(ready),
        .o_tx_data   (tx_data),
        .o_tx_start  (tx_start),
        .i_tx_done   (tx_done),
        .o_busy      (busy),
        .o_done      (done)
    );

    // MSB-first and single-byte builds
    logic        v_rst_n;
    logic        mv_valid, mv_ready, mv_start, mv_busy, mv_odone;
    logic        mv_done = 1'b0;
    logic [31:0] mv_word;
    logic [7:0]  mv_data;
    logic        bv_valid, bv_ready, bv_start, bv_busy, bv_odone;
    logic        bv_done = 1'b0;
    logic [7:0]  bv_word;
    logic [7:0]  bv_data;

    word_tx_serializer #(.NB_WORD(32), .NB_BYTE(8), .LSB_FIRST(1'b0)) u_dut_msb (
        .i_clk       (clk),
        .i_rst_n     (v_rst_n),
        .i_word      (mv_word),
        .i_word_valid(mv_valid),
        .o_word_ready(mv_ready),
        .o_tx_data   (mv_data),
        .o_tx_start  (mv_start),
        .i_tx_done   (mv_done),
        .o_busy      (mv_busy),
        .o_done      (mv_odone)
    );

    word_tx_serializer #(.NB_WORD(8), .NB_BYTE(8), .LSB_FIRST(1'b1)) u_dut_b1 (
        .i_clk       (clk),
        .i_rst_n     (v_rst_n),
        .i_word      (bv_word),
        .i_word_valid(bv_valid),
        .o_word_ready(bv_ready),
        .o_tx_data   (bv_data),
        .o_tx_start  (bv_start),
        .i_tx_done   (bv_done),
        .o_busy      (bv_busy),
        .o_done      (bv_odone)
    );

    // UART stand-ins for the variant builds: done one cycle after each start.
    bit          mv_arm = 1'b0, bv_arm = 1'b0;
    logic [7:0]  mv_bytes[$];
    logic [7:0]  bv_bytes[$];
    int          mv_n_done = 0, bv_n_done = 0;
    int unsigned bv_done_cyc = 0, bv_odone_cyc = 0;

    always @(negedge clk) begin
        mv_done = mv_arm;
        mv_arm  = mv_start;
        if (mv_start) mv_bytes.push_back(mv_data);
        if (mv_odone) mv_n_done++;
        bv_done = bv_arm;
        bv_arm  = bv_start;
        if (bv_done) bv_done_cyc = cyc;
        if (bv_start) bv_bytes.push_back(bv_data);
        if (bv_odone) begin
            bv_n_done++;
            bv_odone_cyc = cyc;
        end
    end

    // Transaction-level reference for the default build
    bit          m_active, m_fin, m_send, m_wait, m_after_rst;
    logic [7:0]  m_q[$];
    logic        p_rst_n, p_valid, p_done;
    logic [31:0] p_word;
    int          cd;
    int          n_acc = 0, n_obs_start = 0, n_obs_done = 0;
    int unsigned last_acc_cyc = 0;
    bit          have_acc;

    // Stimulus policy
    int          g_delay;
    bit          g_gen, g_spurious, g_rst_b2, g_check_gap;
    logic [31:0] g_words[$];
    bit          up_pend;
    logic [31:0] up_word;

    task automatic expect_bytes(input logic [31:0] w);
        for (int i = 0; i < int'(N_BYTES); i++) m_q.push_back(w[8*i +: 8]);
    endtask

    task automatic step();
        logic r, d;
        @(posedge clk);
        #1;
        if (!p_rst_n) begin
            m_active = 0; m_fin = 0; m_send = 0; m_wait = 0; cd = 0;
            m_q.delete();
            m_after_rst = 1;
        end else begin
            m_after_rst = 0;
            if (m_fin) begin
                m_fin = 0;
            end else if (!m_active) begin
                if (p_valid) begin
                    m_active = 1;
                    m_send   = 1;
                    up_pend  = 0;
                    expect_bytes(p_word);
                    n_acc++;
                    if (g_check_gap && have_acc)
                        check_eq("accept_gap", cyc - last_acc_cyc, 2 * N_BYTES + 2);
                    last_acc_cyc = cyc;
                    have_acc     = 1;
                end
            end else if (m_send) begin
                m_send = 0;
                m_wait = 1;
            end else if (m_wait && p_done) begin
                m_wait = 0;
                void'(m_q.pop_front());
                if (m_q.size() == 0) begin
                    m_active = 0;
                    m_fin    = 1;
                end else begin
                    m_send = 1;
                end
            end
        end

        check_eq("word_ready", ready, !m_active && !m_fin);
        check_eq("busy", busy, m_active || m_fin);
        check_eq("tx_start", tx_start, m_send);
        check_eq("done", done, m_fin);
        if (m_active) check_eq("tx_data", tx_data, m_q[0]);
        if (m_after_rst) check_eq("rst_tx_data", tx_data, 0);
        if (tx_start) n_obs_start++;
        if (done) n_obs_done++;

        r = 1'b1;
        if (g_rst_b2 && m_wait && m_q.size() == 3) begin
            r        = 1'b0;
            g_rst_b2 = 0;
        end
        d = 1'b0;
        if (m_send) begin
            cd = (g_delay == 0) ? int'($urandom_range(1, 4)) : g_delay;
            if (g_spurious && $urandom_range(0, 1) == 1) d = 1'b1;
        end else if (cd > 0) begin
            cd--;
            if (cd == 0) d = 1'b1;
        end else if (g_spurious && !m_active && $urandom_range(0, 3) == 0) begin
            d = 1'b1;
        end
        if (!up_pend) begin
            if (g_words.size() > 0) begin
                up_word = g_words.pop_front();
                up_pend = 1;
            end else if (g_gen && $urandom_range(0, 2) == 0) begin
                up_word = $urandom;
                up_pend = 1;
            end
        end
        rst_n   = r;
        tx_done = d;
        valid   = up_pend;
        word    = up_pend ? up_word : $urandom;
        p_rst_n = r;
        p_done  = d;
        p_valid = up_pend;
        p_word  = word;
    endtask

    task automatic run_until_idle();
        int  i;
        bit  idle;
        i = 0;
        do begin
            step();
            i++;
            idle = !m_active && !m_fin && !up_pend && g_words.size() == 0;
        end while (!idle && i < 3000);
        check_eq("idle_reached", idle, 1'b1);
    endtask

    int s_start, s_done, s_acc;

    initial begin
        rst_n = 0; valid = 0; word = '0; tx_done = 0;
        p_rst_n = 0; p_valid = 0; p_done = 0; p_word = '0;
        v_rst_n = 0; mv_valid = 0; mv_word = '0; bv_valid = 0; bv_word = '0;
        g_delay = 3; g_gen = 0; g_spurious = 0; g_rst_b2 = 0; g_check_gap = 0;
        up_pend = 0; up_word = '0; cd = 0; have_acc = 0;
        step();
        v_rst_n = 1;

        // 0xDEADBEEF, done three cycles after each start
        s_start = n_obs_start; s_done = n_obs_done;
        g_words.push_back(32'hDEADBEEF);
        run_until_idle();
        check_eq("deadbeef_starts", n_obs_start - s_start, 4);
        check_eq("deadbeef_dones", n_obs_done - s_done, 1);

        // Spurious done pulses and a second word offered mid-transfer
        s_start = n_obs_start; s_acc = n_acc;
        g_spurious = 1; g_delay = 0;
        g_words.push_back(32'h11223344);
        g_words.push_back(32'h99887766);
        run_until_idle();
        check_eq("spurious_starts", n_obs_start - s_start, 8);
        check_eq("spurious_accepts", n_acc - s_acc, 2);

        // Reset while waiting on byte 2 of 0xCAFEF00D, then a fresh word
        g_spurious = 0; g_delay = 2;
        s_start = n_obs_start; s_done = n_obs_done;
        g_rst_b2 = 1;
        g_words.push_back(32'hCAFEF00D);
        run_until_idle();
        check_eq("reset_hit", g_rst_b2, 1'b0);
        check_eq("reset_starts", n_obs_start - s_start, 2);
        check_eq("reset_no_done", n_obs_done - s_done, 0);
        s_start = n_obs_start; s_done = n_obs_done;
        g_words.push_back(32'h00000001);
        run_until_idle();
        check_eq("post_reset_starts", n_obs_start - s_start, 4);
        check_eq("post_reset_dones", n_obs_done - s_done, 1);

        // Back-to-back words with valid held, done one cycle after each start
        g_delay = 1; g_check_gap = 1; have_acc = 0; s_acc = n_acc;
        g_words.push_back(32'hAAAAAAAA);
        g_words.push_back(32'h55555555);
        run_until_idle();
        check_eq("b2b_accepts", n_acc - s_acc, 2);
        g_check_gap = 0;

        // Random traffic
        g_gen = 1; g_spurious = 1; g_delay = 0;
        repeat (800) step();
        g_gen = 0;
        run_until_idle();

        // MSB-first build
        @(posedge clk); #1;
        mv_valid = 1; mv_word = 32'h12345678;
        @(posedge clk); #1;
        mv_valid = 0; mv_word = $urandom;
        for (int k = 0; k < 40 && mv_n_done == 0; k++) @(posedge clk);
        repeat (4) @(posedge clk);
        check_eq("msb_dones", mv_n_done, 1);
        check_eq("msb_starts", mv_bytes.size(), 4);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] w;
            w = 32'h12345678 >> (8 * (3 - i));
            if (i < mv_bytes.size()) check_eq($sformatf("msb_byte%0d", i), mv_bytes[i], w[7:0]);
        end

        // Single-byte build
        #1;
        bv_valid = 1; bv_word = 8'h5A;
        @(posedge clk); #1;
        bv_valid = 0; bv_word = 8'hFF;
        for (int k = 0; k < 40 && bv_n_done == 0; k++) @(posedge clk);
        repeat (4) @(posedge clk);
        check_eq("b1_dones", bv_n_done, 1);
        check_eq("b1_starts", bv_bytes.size(), 1);
        if (bv_bytes.size() > 0) check_eq("b1_byte", bv_bytes[0], 8'h5A);
        check_eq("b1_done_gap", bv_odone_cyc - bv_done_cyc, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
